// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order write-back queue that drives the register file's single write port.
// Accepts load (priority) and ALU results, retires one write per cycle, and reports pending
// writes for RAW hazard detection. Optional feature macro REGFILE_WB_BYPASS_EN adds forwarding
// outputs carrying the youngest queued data for each query address.
module regfile_writeback #(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [4:0]          mem_rd,
    input  logic [WORDSIZE-1:0] mem_data,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [4:0]          alu_rd,
    input  logic [WORDSIZE-1:0] alu_data,
    output logic                rf_write_en,
    output logic [4:0]          rf_write_addr,
    output logic [WORDSIZE-1:0] rf_write_data,
    input  logic [4:0]          query_addr_a,
    input  logic [4:0]          query_addr_b,
    output logic                hazard_a,
    output logic                hazard_b,
`ifdef REGFILE_WB_BYPASS_EN
    output logic                fwd_valid_a,
    output logic                fwd_valid_b,
    output logic [WORDSIZE-1:0] fwd_data_a,
    output logic [WORDSIZE-1:0] fwd_data_b,
`endif
    output logic                wb_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [4:0]          rd_q   [DEPTH];
    logic [WORDSIZE-1:0] data_q [DEPTH];
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]         count_q, count_d;

    logic                not_full;
    logic                accept_mem;
    logic                accept_alu;
    logic                push;
    logic                pop;
    logic [4:0]          push_rd;
    logic [WORDSIZE-1:0] push_data;
    logic [AW-1:0]       scan_idx;

    // Handshake: ready depends only on registered occupancy; the load path has fixed priority.
    always_comb begin
        not_full   = (count_q < FULL_COUNT);
        mem_ready  = not_full;
        alu_ready  = not_full && !mem_valid;
        accept_mem = mem_valid && mem_ready;
        accept_alu = alu_valid && alu_ready;
        push_rd    = accept_mem ? mem_rd : alu_rd;
        push_data  = accept_mem ? mem_data : alu_data;
        // Writes to x0 complete the handshake but are never queued.
        push       = (accept_mem || accept_alu) && (push_rd != 5'd0);
        pop        = (count_q != '0);
    end

    // Next-state for pointers and occupancy.
    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Queue control state; reset discards any queued writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while covered by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr_q]   <= push_rd;
            data_q[wr_ptr_q] <= push_data;
        end
    end

    // Drain the head every cycle it exists; outputs are zero while empty.
    always_comb begin
        wb_empty      = (count_q == '0);
        rf_write_en   = !wb_empty;
        rf_write_addr = wb_empty ? 5'd0 : rd_q[rd_ptr_q];
        rf_write_data = wb_empty ? '0 : data_q[rd_ptr_q];
    end

    // Scan valid entries oldest to youngest so the last match is the youngest write.
    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        scan_idx = '0;
`ifdef REGFILE_WB_BYPASS_EN
        fwd_data_a = '0;
        fwd_data_b = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if (k[AW:0] < count_q) begin
                scan_idx = rd_ptr_q + k[AW-1:0];
                if (query_addr_a != 5'd0 && rd_q[scan_idx] == query_addr_a) begin
                    hazard_a = 1'b1;
`ifdef REGFILE_WB_BYPASS_EN
                    fwd_data_a = data_q[scan_idx];
`endif
                end
                if (query_addr_b != 5'd0 && rd_q[scan_idx] == query_addr_b) begin
                    hazard_b = 1'b1;
`ifdef REGFILE_WB_BYPASS_EN
                    fwd_data_b = data_q[scan_idx];
`endif
                end
            end
        end
`ifdef REGFILE_WB_BYPASS_EN
        fwd_valid_a = hazard_a;
        fwd_valid_b = hazard_b;
`endif
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_regfile_writeback;

    localparam int unsigned WORDSIZE = 64;
    localparam int unsigned DEPTH    = 4;

    typedef struct packed {
        logic [4:0]          rd;
        logic [WORDSIZE-1:0] data;
    } ent_t;

    logic                clk;
    logic                reset;
    logic                mem_valid;
    logic                mem_ready;
    logic [4:0]          mem_rd;
    logic [WORDSIZE-1:0] mem_data;
    logic                alu_valid;
    logic                alu_ready;
    logic [4:0]          alu_rd;
    logic [WORDSIZE-1:0] alu_data;
    logic                rf_write_en;
    logic [4:0]          rf_write_addr;
    logic [WORDSIZE-1:0] rf_write_data;
    logic [4:0]          query_addr_a;
    logic [4:0]          query_addr_b;
    logic                hazard_a;
    logic                hazard_b;
    logic                wb_empty;
`ifdef REGFILE_WB_BYPASS_EN
    logic                fwd_valid_a;
    logic                fwd_valid_b;
    logic [WORDSIZE-1:0] fwd_data_a;
    logic [WORDSIZE-1:0] fwd_data_b;
`endif

    int tests_run;
    int tests_failed;
    ent_t mq[$];

    regfile_writeback #(
        .WORDSIZE(WORDSIZE),
        .DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .rf_write_en  (rf_write_en),
        .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data),
        .query_addr_a (query_addr_a),
        .query_addr_b (query_addr_b),
        .hazard_a     (hazard_a),
        .hazard_b     (hazard_b),
`ifdef REGFILE_WB_BYPASS_EN
        .fwd_valid_a  (fwd_valid_a),
        .fwd_valid_b  (fwd_valid_b),
        .fwd_data_a   (fwd_data_a),
        .fwd_data_b   (fwd_data_b),
`endif
        .wb_empty     (wb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: any queued entry targeting a nonzero address is pending.
    function automatic logic model_hazard(input logic [4:0] addr);
        logic hit;
        hit = 1'b0;
        foreach (mq[i]) if (addr != 5'd0 && mq[i].rd == addr) hit = 1'b1;
        return hit;
    endfunction

    // Reference: data of the youngest queued entry for addr, else zero.
    function automatic logic [WORDSIZE-1:0] model_fwd(input logic [4:0] addr);
        logic [WORDSIZE-1:0] d;
        d = '0;
        foreach (mq[i]) if (addr != 5'd0 && mq[i].rd == addr) d = mq[i].data;
        return d;
    endfunction

    // One clock: the register file takes the head, then the accepted result (if any) joins the tail.
    task automatic tick();
        logic                room;
        logic                take_mem;
        logic                take_alu;
        logic [4:0]          m_rd;
        logic [4:0]          a_rd;
        logic [WORDSIZE-1:0] m_d;
        logic [WORDSIZE-1:0] a_d;
        room     = (mq.size() < DEPTH);
        take_mem = mem_valid && room;
        take_alu = alu_valid && room && !mem_valid;
        m_rd = mem_rd; m_d = mem_data; a_rd = alu_rd; a_d = alu_data;
        @(posedge clk);
        if (mq.size() > 0) void'(mq.pop_front());
        if (take_mem && m_rd != 5'd0) mq.push_back('{rd: m_rd, data: m_d});
        else if (take_alu && a_rd != 5'd0) mq.push_back('{rd: a_rd, data: a_d});
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        query_addr_a = '0; query_addr_b = '0;
        reset = 1'b0;
        mq.delete();
        repeat (2) @(negedge clk);
        tests_run++;
        if (rf_write_en !== 1'b0 || rf_write_addr !== 5'd0 || rf_write_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_wr: got en=%b addr=%0d data=%h, want 0/0/0",
                     rf_write_en, rf_write_addr, rf_write_data);
        end
        tests_run++;
        if (wb_empty !== 1'b1 || hazard_a !== 1'b0 || hazard_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_status: got empty=%b hz=%b%b, want 1/00", wb_empty, hazard_a,
                     hazard_b);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got mem=%b alu=%b, want 1/1", mem_ready, alu_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (rf_write_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_no_write: got en=%b, want 0", rf_write_en);
            end
        end
    endtask

    task automatic test_single_write();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        #1;
        tests_run++;
        if (alu_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_ready: got %b, want 1", alu_ready);
        end
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd5 || rf_write_data !== 64'h1234) begin
            tests_failed++;
            $display("FAIL single_write: got en=%b addr=%0d data=%h, want 1/5/1234",
                     rf_write_en, rf_write_addr, rf_write_data);
        end
        tick();
        tests_run++;
        if (wb_empty !== 1'b1 || rf_write_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_drained: got empty=%b en=%b, want 1/0", wb_empty, rf_write_en);
        end
    endtask

    task automatic test_priority();
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'hAA;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'hBB;
        #1;
        tests_run++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL prio_ready: got mem=%b alu=%b, want 1/0", mem_ready, alu_ready);
        end
        tick();
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        #1;
        tests_run++;
        if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd3 || rf_write_data !== 64'hAA) begin
            tests_failed++;
            $display("FAIL prio_mem_first: got en=%b addr=%0d data=%h, want 1/3/aa",
                     rf_write_en, rf_write_addr, rf_write_data);
        end
        tests_run++;
        if (alu_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL prio_alu_retry_ready: got %b, want 1", alu_ready);
        end
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd4 || rf_write_data !== 64'hBB) begin
            tests_failed++;
            $display("FAIL prio_alu_second: got en=%b addr=%0d data=%h, want 1/4/bb",
                     rf_write_en, rf_write_addr, rf_write_data);
        end
        tick();
    endtask

    task automatic test_x0_drop();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
        #1;
        tests_run++;
        if (alu_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL x0_ready: got %b, want 1", alu_ready);
        end
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (rf_write_en !== 1'b0 || wb_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL x0_drop: got en=%b empty=%b, want 0/1", rf_write_en, wb_empty);
        end
    endtask

    task automatic test_full_wrap();
        logic [4:0]          exp_rd [$];
        logic [WORDSIZE-1:0] exp_d  [$];
        int                  seen;
        int                  budget;
        seen = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            alu_valid = 1'b1;
            alu_rd    = 5'(i + 10);
            alu_data  = 64'hC0DE_0000 + 64'(i);
            exp_rd.push_back(alu_rd);
            exp_d.push_back(alu_data);
            #1;
            tests_run++;
            if (alu_ready !== (mq.size() < DEPTH)) begin
                tests_failed++;
                $display("FAIL wrap_ready[%0d]: got %b, want %b", i, alu_ready,
                         mq.size() < DEPTH);
            end
            if (rf_write_en === 1'b1) begin
                tests_run++;
                if (rf_write_addr !== exp_rd[seen] || rf_write_data !== exp_d[seen]) begin
                    tests_failed++;
                    $display("FAIL wrap_order[%0d]: got %0d/%h, want %0d/%h", seen,
                             rf_write_addr, rf_write_data, exp_rd[seen], exp_d[seen]);
                end
                seen++;
            end
            tick();
        end
        idle_inputs();
        budget = 4 * DEPTH;
        while (seen < DEPTH + 3 && budget > 0) begin
            #1;
            if (rf_write_en === 1'b1) begin
                tests_run++;
                if (rf_write_addr !== exp_rd[seen] || rf_write_data !== exp_d[seen]) begin
                    tests_failed++;
                    $display("FAIL wrap_order[%0d]: got %0d/%h, want %0d/%h", seen,
                             rf_write_addr, rf_write_data, exp_rd[seen], exp_d[seen]);
                end
                seen++;
            end
            tick();
            budget--;
        end
        tests_run++;
        if (seen != DEPTH + 3) begin
            tests_failed++;
            $display("FAIL wrap_count: got %0d writes, want %0d", seen, DEPTH + 3);
        end
    endtask

    task automatic test_hazard();
        query_addr_a = 5'd7; query_addr_b = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h1;
        tick();
        alu_data = 64'h2;
        #1;
        tests_run++;
        if (hazard_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL hazard_first: got %b, want 1", hazard_a);
        end
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if (hazard_a !== 1'b1 || hazard_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL hazard_second: got a=%b b=%b, want 1/0", hazard_a, hazard_b);
        end
`ifdef REGFILE_WB_BYPASS_EN
        tests_run++;
        if (fwd_valid_a !== 1'b1 || fwd_data_a !== 64'h2) begin
            tests_failed++;
            $display("FAIL fwd_youngest: got v=%b d=%h, want 1/2", fwd_valid_a, fwd_data_a);
        end
`endif
        // Asynchronous reset away from any clock edge.
        #2;
        reset = 1'b0;
        #1;
        mq.delete();
        tests_run++;
        if (hazard_a !== 1'b0 || rf_write_en !== 1'b0 || wb_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_drain: got hz=%b en=%b empty=%b, want 0/0/1", hazard_a,
                     rf_write_en, wb_empty);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tests_run++;
        if (rf_write_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_lost_writes: got en=%b, want 0", rf_write_en);
        end
    endtask

    task automatic test_random();
        ent_t head;
        for (int c = 0; c < 300; c++) begin
            mem_valid    = ($urandom_range(0, 3) == 0);
            mem_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mem_data     = {$urandom, $urandom};
            alu_valid    = ($urandom_range(0, 1) == 0);
            alu_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_data     = {$urandom, $urandom};
            query_addr_a = 5'($urandom_range(0, 31));
            query_addr_b = (mq.size() > 0 && $urandom_range(0, 1) == 0) ? mq[0].rd
                                                                         : 5'($urandom_range(0, 31));
            #1;
            tests_run++;
            if (mem_ready !== (mq.size() < DEPTH) ||
                alu_ready !== (mq.size() < DEPTH && !mem_valid)) begin
                tests_failed++;
                $display("FAIL rand_ready[%0d]: got mem=%b alu=%b", c, mem_ready, alu_ready);
            end
            tests_run++;
            if (mq.size() == 0) begin
                if (rf_write_en !== 1'b0 || wb_empty !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rand_empty[%0d]: got en=%b empty=%b, want 0/1", c,
                             rf_write_en, wb_empty);
                end
            end else begin
                head = mq[0];
                if (rf_write_en !== 1'b1 || rf_write_addr !== head.rd ||
                    rf_write_data !== head.data) begin
                    tests_failed++;
                    $display("FAIL rand_write[%0d]: got en=%b %0d/%h, want 1 %0d/%h", c,
                             rf_write_en, rf_write_addr, rf_write_data, head.rd, head.data);
                end
            end
            tests_run++;
            if (hazard_a !== model_hazard(query_addr_a) ||
                hazard_b !== model_hazard(query_addr_b)) begin
                tests_failed++;
                $display("FAIL rand_hazard[%0d]: got a=%b b=%b, want a=%b b=%b", c, hazard_a,
                         hazard_b, model_hazard(query_addr_a), model_hazard(query_addr_b));
            end
`ifdef REGFILE_WB_BYPASS_EN
            tests_run++;
            if (fwd_data_a !== model_fwd(query_addr_a) || fwd_data_b !== model_fwd(query_addr_b)
                || fwd_valid_a !== model_hazard(query_addr_a)) begin
                tests_failed++;
                $display("FAIL rand_fwd[%0d]: got a=%h b=%h", c, fwd_data_a, fwd_data_b);
            end
`endif
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single_write();
        test_priority();
        test_x0_drop();
        test_full_wrap();
        test_hazard();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
